// File: rtl/memory_stage.sv
// memory_stage: EX/MEM and MEM/WB pipeline registers with a two-state handshake to data memory.
// Optional alignment trap enabled by defining MEMORY_STAGE_ALIGN_CHECK_EN.
module memory_stage #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] PCBranch_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic         zero_E,
   input  logic         Branch_E,
   input  logic         MemRead_E,
   input  logic         MemWrite_E,
   input  logic         RegWrite_E,
   input  logic         MemtoReg_E,
   input  logic [4:0]   rd_E,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic [N-1:0] dm_rdata,
   input  logic         dm_ack,
   output logic [N-1:0] PCBranch_M,
   output logic         PCSrc_M,
   output logic         stall_M,
   output logic [N-1:0] readData_W,
   output logic [N-1:0] aluResult_W,
   output logic         RegWrite_W,
   output logic         MemtoReg_W,
   output logic [4:0]   rd_W,
   output logic         misalign_M
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t       r_state;
   logic [N-1:0] r_pcbranch, r_alu, r_wdata;
   logic         r_zero, r_branch, r_memread, r_memwrite, r_regwrite, r_memtoreg;
   logic [4:0]   r_rd;
   logic         w_memop, w_mis, w_done;
   assign w_memop = r_memread | r_memwrite;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
   assign w_mis = w_memop & (|r_alu[2:0]);
`else
   assign w_mis = 1'b0;
`endif
   assign w_done     = (r_state == BUSY) & dm_ack;
   assign stall_M    = w_memop & ~w_mis & ~w_done;
   assign misalign_M = w_mis;
   assign PCSrc_M    = r_branch & r_zero;
   assign PCBranch_M = r_pcbranch;
   assign dm_req     = (r_state == BUSY);
   assign dm_we      = dm_req & r_memwrite;
   assign dm_addr    = r_alu;
   assign dm_wdata   = r_wdata;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pcbranch  <= '0;
         r_alu       <= '0;
         r_wdata     <= '0;
         r_zero      <= 1'b0;
         r_branch    <= 1'b0;
         r_memread   <= 1'b0;
         r_memwrite  <= 1'b0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_rd        <= '0;
         readData_W  <= '0;
         aluResult_W <= '0;
         RegWrite_W  <= 1'b0;
         MemtoReg_W  <= 1'b0;
         rd_W        <= '0;
      end else begin
         r_state <= (r_state == IDLE) ? ((w_memop & ~w_mis) ? BUSY : IDLE) : (dm_ack ? IDLE : BUSY);
         if (!stall_M) begin
            r_pcbranch <= PCBranch_E;
            r_alu      <= aluResult_E;
            r_wdata    <= writeData_E;
            r_zero     <= zero_E;
            r_branch   <= Branch_E;
            r_memread  <= MemRead_E;
            r_memwrite <= MemWrite_E;
            r_regwrite <= RegWrite_E;
            r_memtoreg <= MemtoReg_E;
            r_rd       <= rd_E;
         end
         // a stalled or trapped access retires as a bubble
         readData_W  <= (stall_M | w_mis) ? '0 : ((r_memread & w_done) ? dm_rdata : '0);
         aluResult_W <= (stall_M | w_mis) ? '0 : r_alu;
         RegWrite_W  <= (stall_M | w_mis) ? 1'b0 : r_regwrite;
         MemtoReg_W  <= (stall_M | w_mis) ? 1'b0 : r_memtoreg;
         rd_W        <= (stall_M | w_mis) ? 5'd0 : r_rd;
      end
   end
endmodule
